cordic_pol2rect: RTL and testbench

//  Iterative CORDIC in rotation mode: converts polar (amp, phi) to rectangular (re, im).
//  It is the inverse of the vectoring CORDIC. It sits on the synthesis side of the same

---
 rtl/cordic_pkg.sv | 29 ++
 rtl/cordic_rot_iter.sv | 34 +++
 rtl/cordic_pol2rect.sv | 152 +++++++++++++++
 tb/tb_cordic_pol2rect.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cordic_pkg.sv
// Shared CORDIC constants, arctangent table and FSM state type.
// Used by both the rotation (pol2rect) and vectoring CORDICs.
package cordic_pkg;

  localparam int K_INV    = 2487;
  localparam int PI       = 1024;
  localparam int PI_DIV_2 = 512;

  // round(atan(2^-i) * 1024 / pi)
  localparam int ALPHA [10] = '{
    256, 151, 80, 41, 20, 10, 5, 3, 1, 1
  };

  typedef enum logic [2:0] {
    IDLE,
    PRE,
    ITER,
    POST,
    OUT
  } pol2rect_state_t;

  function automatic logic [8:0] alpha_of(
    input logic [3:0] i
  );
    if (i < 4'd10) return 9'(ALPHA[i]);
    return '0;
  endfunction

endpackage

// File: rtl/cordic_rot_iter.sv
// One combinational CORDIC micro-rotation (rotation mode).
// Ports: x/y/z in, shift index, alpha; x_n/y_n/z_n out.
module cordic_rot_iter #(
  parameter int XW = 16,
  parameter int ZW = 12
) (
  input  logic signed [XW-1:0] x,
  input  logic signed [XW-1:0] y,
  input  logic signed [ZW-1:0] z,
  input  logic        [3:0]    shift,
  input  logic signed [ZW-1:0] alpha,
  output logic signed [XW-1:0] x_n,
  output logic signed [XW-1:0] y_n,
  output logic signed [ZW-1:0] z_n
);

  logic signed [XW-1:0] xs;
  logic signed [XW-1:0] ys;

  always_comb begin
    xs = x >>> shift;
    ys = y >>> shift;
    if (!z[ZW-1]) begin
      x_n = x - ys;
      y_n = y + xs;
      z_n = z - alpha;
    end else begin
      x_n = x + ys;
      y_n = y - xs;
      z_n = z + alpha;
    end
  end

endmodule

// File: rtl/cordic_pol2rect.sv
// Iterative rotation-mode CORDIC: (amp, phi) -> (re, im), one sample in flight.
// Ports: clk_i, rst_ni, amp_i/phi_i/valid_i/ready_o in, re_o/im_o/valid_o/ready_i out.
module cordic_pol2rect
  import cordic_pkg::*;
#(
  parameter int N_ITER = 10,
  parameter int DATA_W = 12,
  parameter int PHI_W  = 11,
  parameter int FRAC   = 3
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic        [DATA_W-1:0] amp_i,
  input  logic signed [PHI_W-1:0]  phi_i,
  input  logic                     valid_i,
  output logic                     ready_o,
  output logic signed [DATA_W-1:0] re_o,
  output logic signed [DATA_W-1:0] im_o,
  output logic                     valid_o,
  input  logic                     ready_i
);

  localparam int XW = DATA_W + FRAC + 1;
  localparam int ZW = PHI_W + 1;
  localparam int PW = DATA_W + 13;

  localparam logic signed [ZW-1:0] Z_HALF = ZW'(PI_DIV_2);
  localparam logic signed [ZW-1:0] Z_PI   = ZW'(PI);
  localparam logic signed [XW-1:0] SMAX   = XW'(2**(DATA_W-1) - 1);

  pol2rect_state_t state_q, state_d;

  logic        [DATA_W-1:0] amp_q;
  logic signed [PHI_W-1:0]  phi_q;
  logic signed [XW-1:0]     x_q, y_q;
  logic signed [ZW-1:0]     z_q;
  logic        [3:0]        cnt_q;

  logic signed [XW-1:0] x_mag, x0;
  logic signed [ZW-1:0] phi_ext, z0;
  logic signed [XW-1:0] x_n, y_n;
  logic signed [ZW-1:0] z_n, alpha;
  logic                 accept;

  assign accept = valid_i & ready_o;

  // gain-compensated start vector, rounded into FRAC guard bits
  assign x_mag = XW'(
    (PW'(amp_q) * PW'(K_INV) + PW'(2**(11-FRAC))) >> (12-FRAC)
  );
  assign phi_ext = ZW'(phi_q);

  // fold |phi| > pi/2 into the CORDIC range by a half-turn
  always_comb begin
    z0 = phi_ext;
    x0 = x_mag;
    if (phi_ext > Z_HALF) begin
      z0 = phi_ext - Z_PI;
      x0 = -x_mag;
    end else if (phi_ext < -Z_HALF) begin
      z0 = phi_ext + Z_PI;
      x0 = -x_mag;
    end
  end

  assign alpha = ZW'(alpha_of(cnt_q));

  cordic_rot_iter #(
    .XW(XW),
    .ZW(ZW)
  ) u_iter (
    .x    (x_q),
    .y    (y_q),
    .z    (z_q),
    .shift(cnt_q),
    .alpha(alpha),
    .x_n  (x_n),
    .y_n  (y_n),
    .z_n  (z_n)
  );

  function automatic logic signed [DATA_W-1:0] round_sat(
    input logic signed [XW-1:0] v
  );
    logic signed [XW-1:0] r;
    r = (v + XW'(2**(FRAC-1))) >>> FRAC;
    if (r > SMAX) r = SMAX;
    else if (r < -SMAX) r = -SMAX;
    return r[DATA_W-1:0];
  endfunction

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (accept) state_d = PRE;
      PRE:  state_d = ITER;
      ITER: if (cnt_q == 4'(N_ITER-1)) state_d = POST;
      POST: state_d = OUT;
      OUT:  if (ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ready_o <= 1'b0;
      valid_o <= 1'b0;
      re_o    <= '0;
      im_o    <= '0;
      amp_q   <= '0;
      phi_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
      z_q     <= '0;
      cnt_q   <= '0;
    end else begin
      ready_o <= (state_d == IDLE);
      valid_o <= (state_d == OUT);
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            amp_q <= amp_i;
            phi_q <= phi_i;
          end
        end
        PRE: begin
          x_q   <= x0;
          y_q   <= '0;
          z_q   <= z0;
          cnt_q <= '0;
        end
        ITER: begin
          x_q   <= x_n;
          y_q   <= y_n;
          z_q   <= z_n;
          cnt_q <= cnt_q + 4'd1;
        end
        POST: begin
          re_o <= round_sat(x_q);
          im_o <= round_sat(y_q);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cordic_pol2rect.sv
// Bench for cordic_pol2rect: directed scenarios plus random samples
// against an integer algorithm model and a trig sanity model.
module tb_cordic_pol2rect;

  logic               clk_i;
  logic               rst_ni;
  logic        [11:0] amp_i;
  logic signed [10:0] phi_i;
  logic               valid_i;
  logic               ready_o;
  logic signed [11:0] re_o;
  logic signed [11:0] im_o;
  logic               valid_o;
  logic               ready_i;

  int n_cmp = 0;
  int n_bad = 0;

  localparam int TAB [10] = '{256, 151, 80, 41, 20, 10, 5, 3, 1, 1};

  cordic_pol2rect dut (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .amp_i  (amp_i),
    .phi_i  (phi_i),
    .valid_i(valid_i),
    .ready_o(ready_o),
    .re_o   (re_o),
    .im_o   (im_o),
    .valid_o(valid_o),
    .ready_i(ready_i)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic check(
    input string tag,
    input int    obs,
    input int    exp,
    input int    tol
  );
    int diff;
    n_cmp++;
    diff = obs - exp;
    if (diff < 0) diff = -diff;
    if (diff > tol) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d (tol %0d)", tag, obs, exp, tol);
    end
  endtask

  function automatic int sat(input int v);
    if (v > 2047) return 2047;
    if (v < -2047) return -2047;
    return v;
  endfunction

  // Algorithm-level model: gain compensation, half-turn fold,
  // ten micro-rotations on plain integers, round and saturate.
  function automatic void model(
    input  int amp,
    input  int phi,
    output int re,
    output int im
  );
    int x, y, z, xn, d;
    x = (amp * 2487 + 256) >>> 9;
    y = 0;
    z = phi;
    if (phi > 512) begin
      z = phi - 1024;
      x = -x;
    end else if (phi < -512) begin
      z = phi + 1024;
      x = -x;
    end
    for (int i = 0; i < 10; i++) begin
      d  = (z >= 0) ? 1 : -1;
      xn = x - d * (y >>> i);
      y  = y + d * (x >>> i);
      x  = xn;
      z  = z - d * TAB[i];
    end
    re = sat((x + 4) >>> 3);
    im = sat((y + 4) >>> 3);
  endfunction

  function automatic int trig(input int amp, input int phi, input bit s);
    real a, v;
    a = phi * 3.14159265358979 / 1024.0;
    v = s ? amp * $sin(a) : amp * $cos(a);
    return $rtoi($floor(v + 0.5));
  endfunction

  task automatic wait_ready();
    int t = 0;
    while (!ready_o && t < 50) begin
      @(posedge clk_i);
      #1;
      t++;
    end
    if (!ready_o) check("ready_timeout", 0, 1, 0);
  endtask

  task automatic send(
    input  int amp,
    input  int phi,
    input  int hold,
    output int re,
    output int im
  );
    int lat, hre, him;
    wait_ready();
    amp_i   = 12'(amp);
    phi_i   = 11'(phi);
    valid_i = 1'b1;
    ready_i = 1'b0;
    @(posedge clk_i);
    #1;
    valid_i = 1'b0;
    check("rdy_drop", int'(ready_o), 0, 0);
    lat = 0;
    while (!valid_o && lat < 40) begin
      @(posedge clk_i);
      #1;
      lat++;
    end
    check("latency", lat, 12, 0);
    re = int'(re_o);
    im = int'(im_o);
    hre = re;
    him = im;
    for (int h = 0; h < hold; h++) begin
      amp_i   = 12'($urandom_range(0, 2047));
      phi_i   = 11'($urandom);
      valid_i = 1'b1;
      @(posedge clk_i);
      #1;
      check("hold_valid", int'(valid_o), 1, 0);
      check("hold_ready", int'(ready_o), 0, 0);
      check("hold_re", int'(re_o), hre, 0);
      check("hold_im", int'(im_o), him, 0);
    end
    valid_i = 1'b0;
    ready_i = 1'b1;
    @(posedge clk_i);
    #1;
    ready_i = 1'b0;
    check("out_clear", int'(valid_o), 0, 0);
    check("out_ready", int'(ready_o), 1, 0);
  endtask

  task automatic run_exact(
    input string tag,
    input int    amp,
    input int    phi,
    input int    hold,
    output int   re,
    output int   im
  );
    int mre, mim;
    send(amp, phi, hold, re, im);
    model(amp, phi, mre, mim);
    check({tag, "_re"}, re, mre, 0);
    check({tag, "_im"}, im, mim, 0);
  endtask

  int amps [8] = '{1000, 1000, 1000, 1414, 1414, 1000, 1000, 2047};
  int phis [8] = '{0, 512, -512, 256, -768, -1024, 1023, 0};

  initial begin
    int re, im, a, p, busy;
    rst_ni  = 1'b0;
    amp_i   = '0;
    phi_i   = '0;
    valid_i = 1'b0;
    ready_i = 1'b0;
    #23;
    check("rst_ready", int'(ready_o), 0, 0);
    check("rst_valid", int'(valid_o), 0, 0);
    check("rst_re", int'(re_o), 0, 0);
    check("rst_im", int'(im_o), 0, 0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(posedge clk_i);
    #1;
    check("rdy_after_rst", int'(ready_o), 1, 0);

    for (int k = 0; k < 8; k++) begin
      run_exact($sformatf("dir%0d", k), amps[k], phis[k], 0, re, im);
      if (k < 3) begin
        check($sformatf("trig%0d_re", k), re, trig(amps[k], phis[k], 0), 2);
        check($sformatf("trig%0d_im", k), im, trig(amps[k], phis[k], 1), 2);
      end
    end
    check("full_scale_re", re, 2047, 2);

    run_exact("hold", 1414, 256, 5, re, im);
    busy = 0;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk_i);
      #1;
      if (valid_o || !ready_o) busy++;
    end
    check("no_queued", busy, 0, 0);

    wait_ready();
    amp_i   = 12'd1500;
    phi_i   = 11'sd300;
    valid_i = 1'b1;
    @(posedge clk_i);
    #1;
    valid_i = 1'b0;
    repeat (5) @(posedge clk_i);
    #3;
    rst_ni = 1'b0;
    #1;
    check("midrst_valid", int'(valid_o), 0, 0);
    check("midrst_ready", int'(ready_o), 0, 0);
    check("midrst_re", int'(re_o), 0, 0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(posedge clk_i);
    #1;
    check("midrst_rdy_back", int'(ready_o), 1, 0);
    run_exact("after_rst", 500, 0, 0, re, im);
    check("after_rst_trig_re", re, 500, 2);
    check("after_rst_trig_im", im, 0, 2);

    for (int r = 0; r < 30; r++) begin
      a = $urandom_range(0, 2047);
      p = $urandom_range(0, 2047) - 1024;
      run_exact($sformatf("rnd%0d", r), a, p, $urandom_range(0, 3), re, im);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
